data_mem_responder: RTL and testbench

//   Target-side end of the CPU data-memory interface: accepts one load/store request
//   at a time over a valid/ready handshake and returns one response per request.

---
 rtl/data_mem_responder_if.sv | 27 ++
 rtl/data_mem_responder.sv | 114 +++++++++++
 tb/tb_data_mem_responder.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between a data-memory initiator (CPU load/store path)
// and the data_mem_responder target.
interface data_mem_responder_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory target with programmable wait states. It handles one
// request at a time and returns one response per request; out-of-range addresses are flagged.
module data_mem_responder #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   data_mem_responder_if.slave   bus
);
   localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]      WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            r_state;
   logic              r_req_ready;
   logic              r_rsp_valid;
   logic              r_busy;
   logic              r_rsp_err;
   logic              r_rsp_sel;
   logic [3:0]        r_cnt;
   logic [DATA_W-1:0] r_rd_q;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_accept;
   logic              w_in_range;
   logic [IDX_W-1:0]  w_idx;
   logic              w_wr_en;
   logic              w_rd_en;

   // No aliasing: any address at or above DEPTH is an error, whatever the upper bits hold.
   assign w_in_range = ({1'b0, bus.req_addr} < DEPTH_L);
   assign w_idx      = bus.req_addr[IDX_W-1:0];
   assign w_accept   = bus.req_valid & r_req_ready;
   assign w_wr_en    = w_accept & bus.req_we & w_in_range & ~rst;
   assign w_rd_en    = w_accept & ~bus.req_we & w_in_range;

   // Storage is deliberately left out of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_idx] <= bus.req_wdata;
      end
      if (w_rd_en) begin
         r_rd_q <= r_mem[w_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_sel   <= 1'b0;
         r_cnt       <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_rsp_err   <= ~w_in_range;
                  r_rsp_sel   <= ~bus.req_we & w_in_range;
                  if (WAIT_CYCLES == 0) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= WAIT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_state     <= S_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_req_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   // Stores and errors report zero data; loads report the word captured at accept.
   assign bus.rsp_rdata = r_rsp_sel ? r_rd_q : '0;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.req_ready = r_req_ready;
   assign bus.busy      = r_busy;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) driven with directed and random
// traffic, checked against an array-based memory model and per-request latency rules.
module tb_data_mem_responder;
   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int DEPTH = 256;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int resp_cnt [2] = '{0, 0};
   int rr_mode  [2] = '{1, 1};

   logic        d_valid  [2];
   logic        d_we     [2];
   logic [15:0] d_addr   [2];
   logic [15:0] d_wdata  [2];
   logic        d_rready [2] = '{1'b1, 1'b1};
   logic        m_rvalid [2];
   logic        m_qready [2];
   logic        m_err    [2];
   logic        m_busy   [2];
   logic [15:0] m_rdata  [2];

   logic [15:0] ref_mem [2][DEPTH];
   exp_t qa[$];
   exp_t qb[$];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         data_mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
         assign bus.req_valid = d_valid[gi];
         assign bus.req_we    = d_we[gi];
         assign bus.req_addr  = d_addr[gi];
         assign bus.req_wdata = d_wdata[gi];
         assign bus.rsp_ready = d_rready[gi];
         assign m_rvalid[gi]  = bus.rsp_valid;
         assign m_qready[gi]  = bus.req_ready;
         assign m_err[gi]     = bus.rsp_err;
         assign m_busy[gi]    = bus.busy;
         assign m_rdata[gi]   = bus.rsp_rdata;
         data_mem_responder #(
            .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES((gi == 0) ? 2 : 0)
         ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
         );
      end
   endgenerate

   // rsp_ready policy per DUT: 0 = held low, 1 = held high, 2 = random backpressure.
   always begin
      @(posedge clk);
      #2;
      for (int w = 0; w < 2; w++) begin
         case (rr_mode[w])
            0:       d_rready[w] = 1'b0;
            1:       d_rready[w] = 1'b1;
            default: d_rready[w] = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s timed out (t=%0t)", name, $time);
   endtask

   function automatic exp_t model(input int w, input logic we, input logic [15:0] addr,
                                  input logic [15:0] wdata);
      exp_t e;
      e.err   = (addr >= 16'(DEPTH));
      e.rdata = 16'h0000;
      e.acc   = 0;
      if (!e.err) begin
         if (we) ref_mem[w][addr[7:0]] = wdata;
         else    e.rdata = ref_mem[w][addr[7:0]];
      end
      return e;
   endfunction

   function automatic int qsize(input int w);
      return (w == 0) ? qa.size() : qb.size();
   endfunction

   function automatic exp_t qfront(input int w);
      return (w == 0) ? qa[0] : qb[0];
   endfunction

   function automatic exp_t qpop(input int w);
      if (w == 0) return qa.pop_front();
      return qb.pop_front();
   endfunction

   function automatic void qpush(input int w, input exp_t e);
      if (w == 0) qa.push_back(e);
      else        qb.push_back(e);
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic issue(input int w, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input bit hold, output int acc);
      int   n;
      exp_t e;
      d_valid[w] = 1'b1;
      d_we[w]    = we;
      d_addr[w]  = addr;
      d_wdata[w] = wdata;
      acc        = -1;
      n          = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_qready[w] && n < 100);
      if (!m_qready[w]) begin
         timeout_fail("accept");
         d_valid[w] = 1'b0;
         return;
      end
      e     = model(w, we, addr, wdata);
      e.acc = cyc + 1;
      acc   = e.acc;
      qpush(w, e);
      $display("req dut%0d we=%0d addr=%04h wdata=%04h edge=%0d", w, we, addr, wdata, acc);
      @(posedge clk);
      #1;
      if (!hold) d_valid[w] = 1'b0;
   endtask

   task automatic monitor(input int w, input int wc);
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b0;
            continue;
         end
         check($sformatf("ready_vs_busy%0d", w), m_qready[w], !m_busy[w]);
         check($sformatf("no_overlap%0d", w), m_rvalid[w] & m_qready[w], 0);
         if (m_rvalid[w] && !prev) begin
            if (qsize(w) == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp%0d got response with empty scoreboard", w);
            end else begin
               e = qfront(w);
               check($sformatf("latency%0d", w), cyc - e.acc, wc);
            end
         end
         if (m_rvalid[w] && d_rready[w] && qsize(w) > 0) begin
            e = qpop(w);
            $display("rsp dut%0d rdata=%04h err=%0d exp_rdata=%04h exp_err=%0d",
                     w, m_rdata[w], m_err[w], e.rdata, e.err);
            check($sformatf("rdata%0d", w), m_rdata[w], e.rdata);
            check($sformatf("err%0d", w), m_err[w], e.err);
            resp_cnt[w]++;
         end
         prev = m_rvalid[w];
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((qsize(0) != 0 || qsize(1) != 0) && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (qsize(0) != 0 || qsize(1) != 0) timeout_fail("drain");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int n;
      int prev_acc;
      int base;
      logic [15:0] a;
      for (int w = 0; w < 2; w++) begin
         d_valid[w] = 1'b0;
         d_we[w]    = 1'b0;
         d_addr[w]  = 16'h0;
         d_wdata[w] = 16'h0;
      end
      fork
         monitor(0, 2);
         monitor(1, 0);
      join_none

      repeat (3) @(posedge clk);
      #1;
      for (int w = 0; w < 2; w++) begin
         check("reset_rsp_valid", m_rvalid[w], 0);
         check("reset_req_ready", m_qready[w], 1);
         check("reset_busy", m_busy[w], 0);
         check("reset_rdata", m_rdata[w], 0);
         check("reset_err", m_err[w], 0);
      end
      rst = 1'b0;

      // Power-up preload: every implemented word set to zero in both DUTs.
      fork
         begin
            int ta;
            for (int i = 0; i < DEPTH; i++) issue(0, 1'b1, 16'(i), 16'h0000, 1'b0, ta);
         end
         begin
            int tb;
            for (int i = 0; i < DEPTH; i++) issue(1, 1'b1, 16'(i), 16'h0000, 1'b0, tb);
         end
      join
      drain();

      issue(0, 1'b1, 16'h0005, 16'hBEEF, 1'b0, t);
      issue(0, 1'b0, 16'h0005, 16'h0000, 1'b0, t);
      issue(0, 1'b0, 16'h0006, 16'h0000, 1'b0, t);
      issue(0, 1'b1, 16'h0100, 16'h1234, 1'b0, t);
      issue(0, 1'b0, 16'h0000, 16'h0000, 1'b0, t);
      issue(0, 1'b0, 16'h0100, 16'h0000, 1'b0, t);
      drain();

      // Held-off response with a competing request that must not be taken.
      rr_mode[0] = 0;
      issue(0, 1'b0, 16'h0005, 16'h0000, 1'b0, t);
      d_valid[0] = 1'b1;
      d_we[0]    = 1'b1;
      d_addr[0]  = 16'h0005;
      d_wdata[0] = 16'h1111;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_rvalid[0] && n < 20);
      if (!m_rvalid[0]) timeout_fail("hold_rsp_valid");
      repeat (5) begin
         @(negedge clk);
         check("hold_valid", m_rvalid[0], 1);
         check("hold_rdata", m_rdata[0], 16'hBEEF);
         check("hold_req_ready", m_qready[0], 0);
      end
      @(posedge clk);
      #1;
      d_valid[0] = 1'b0;
      rr_mode[0] = 1;
      @(posedge clk);
      #1;
      check("idle_after_rsp_ready", m_qready[0], 1);
      check("idle_after_rsp_busy", m_busy[0], 0);
      issue(0, 1'b0, 16'h0005, 16'h0000, 1'b0, t);
      drain();

      // Reset in WAIT after a store: response dropped, store kept.
      issue(0, 1'b1, 16'h0007, 16'hA5A5, 1'b0, t);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_rsp_valid", m_rvalid[0], 0);
      check("midrst_req_ready", m_qready[0], 1);
      check("midrst_rdata", m_rdata[0], 0);
      check("midrst_err", m_err[0], 0);
      rst = 1'b0;
      if (qa.size() > 0) void'(qa.pop_back());
      issue(0, 1'b0, 16'h0007, 16'h0000, 1'b0, t);
      drain();

      // Random traffic with backpressure on the 2-wait-state DUT.
      rr_mode[0] = 2;
      for (int i = 0; i < 150; i++) begin
         int r;
         bit h;
         r = $urandom_range(0, 9);
         if (r == 0)      a = 16'($urandom);
         else if (r == 1) a = 16'($urandom_range(256, 259));
         else             a = 16'($urandom_range(0, 15));
         h = 1'($urandom_range(0, 1));
         issue(0, 1'($urandom_range(0, 1)), a, 16'($urandom), h, t);
         if (!h) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
      end
      d_valid[0] = 1'b0;
      rr_mode[0] = 1;
      drain();

      // Zero-wait DUT: back-to-back requests accept every two edges.
      base     = resp_cnt[1];
      prev_acc = -1;
      for (int i = 0; i < 20; i++) begin
         a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 300)) : 16'($urandom_range(0, 7));
         issue(1, 1'($urandom_range(0, 1)), a, 16'($urandom), (i < 19), t);
         if (i > 0) check("b2b_spacing", t - prev_acc, 2);
         prev_acc = t;
      end
      drain();
      check("b2b_count", resp_cnt[1] - base, 20);
      check("final_queue_a", qa.size(), 0);
      check("final_queue_b", qb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
